piso_tx: RTL and testbench



---
 rtl/piso_tx.sv | 108 ++++++++++
 tb/tb_piso_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first serial output.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [FrameLen-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                s_out_q, s_out_d;
  logic                s_valid_q, s_valid_d;
  logic                s_last_q, s_last_d;
  logic                busy_q, busy_d;
  logic                last_bit;
  logic                xfer;
  logic [FrameLen-1:0] load_word;

  // The parity bit rides in the shift register below the data, so it leaves after bit 0.
`ifdef PISO_PARITY_EN
  assign load_word = {p_in, ^p_in};
`else
  assign load_word = p_in;
`endif

  assign last_bit   = (state_q == StShift) && (cnt_q == LastCnt);
  assign load_ready = (state_q == StIdle) || last_bit;
  assign xfer       = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      state_d = StShift;
      shreg_d = load_word;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      if (last_bit) begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = {shreg_q[FrameLen-2:0], 1'b0};
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with the new bit.
  always_comb begin
    s_out_d   = 1'b0;
    s_valid_d = 1'b0;
    s_last_d  = 1'b0;
    busy_d    = 1'b0;
    if (state_d == StShift) begin
      s_out_d   = shreg_d[FrameLen-1];
      s_valid_d = 1'b1;
      s_last_d  = (cnt_d == LastCnt);
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
      busy_q    <= busy_d;
    end
  end

  assign s_out   = s_out_q;
  assign s_valid = s_valid_q;
  assign s_last  = s_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed and random loads checked against a frame-queue model,
// plus shift-receiver loopback at WIDTH=8 and WIDTH=2.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif
  localparam int FL  = 8 + (Par ? 1 : 0);
  localparam int FL2 = 2 + (Par ? 1 : 0);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] p_in;
  logic       load_valid, load_ready, s_out, s_valid, s_last, busy;
  logic [1:0] p_in2;
  logic       load_valid2, load_ready2, s_out2, s_valid2, s_last2, busy2;
  logic [7:0] rx;
  logic [1:0] rx2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic b; logic last;} fbit_t;
  fbit_t q[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .p_in(p_in), .load_valid(load_valid),
    .load_ready(load_ready), .s_out(s_out), .s_valid(s_valid), .s_last(s_last), .busy(busy)
  );

  piso_tx #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .p_in(p_in2), .load_valid(load_valid2),
    .load_ready(load_ready2), .s_out(s_out2), .s_valid(s_valid2), .s_last(s_last2),
    .busy(busy2)
  );

  // Shift-left receivers loading each valid bit at LSB.
  always @(posedge clk) begin
    if (reset) begin
      rx  <= '0;
      rx2 <= '0;
    end else begin
      if (s_valid)  rx  <= {rx[6:0], s_out};
      if (s_valid2) rx2 <= {rx2[0], s_out2};
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q.push_back('{b: w[i], last: (!Par && i == 0)});
    if (Par) q.push_back('{b: ^w, last: 1'b1});
  endtask

  // One clock: apply inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic lv, input logic [7:0] w, input logic r);
    logic ev, eo, el, er;
    load_valid = lv;
    p_in       = w;
    reset      = r;
    @(negedge clk);
    ev = (q.size() > 0);
    eo = ev ? q[0].b : 1'b0;
    el = ev ? q[0].last : 1'b0;
    er = (q.size() <= 1);
    chk("s_valid", {7'd0, s_valid}, {7'd0, ev});
    chk("s_out", {7'd0, s_out}, {7'd0, eo});
    chk("s_last", {7'd0, s_last}, {7'd0, el});
    chk("busy", {7'd0, busy}, {7'd0, ev});
    chk("load_ready", {7'd0, load_ready}, {7'd0, er});
    if (r) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (lv && er) push_frame(w);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rx_exp8(input logic [7:0] w);
    return Par ? {w[6:0], ^w} : w;
  endfunction

  initial begin
    logic [1:0] w2;
    reset       = 1'b1;
    load_valid  = 1'b0;
    p_in        = '0;
    load_valid2 = 1'b0;
    p_in2       = '0;
    @(posedge clk);
    #1;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hEE, 1'b1);  // reset wins over a simultaneous load
    cycle(1'b0, 8'h00, 1'b0);

    // Single frame and full drain.
    cycle(1'b1, 8'hA5, 1'b0);
    repeat (FL + 2) cycle(1'b0, 8'h00, 1'b0);

    // Back-to-back: second word held until accepted on the last bit.
    cycle(1'b1, 8'hA5, 1'b0);
    repeat (FL) cycle(1'b1, 8'h3C, 1'b0);
    repeat (FL + 2) cycle(1'b0, 8'h00, 1'b0);

    // Load pulse mid-frame must be ignored.
    cycle(1'b1, 8'h00, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    repeat (FL + 1) cycle(1'b0, 8'h00, 1'b0);

    // Reset mid-frame, then a fresh frame.
    cycle(1'b1, 8'hF0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h81, 1'b0);
    repeat (FL + 1) cycle(1'b0, 8'h00, 1'b0);

    // Parity examples (plain frames without the feature).
    cycle(1'b1, 8'h07, 1'b0);
    repeat (FL + 1) cycle(1'b0, 8'h00, 1'b0);

    // Loopback WIDTH=8.
    cycle(1'b1, 8'hC3, 1'b0);
    repeat (FL) cycle(1'b0, 8'h00, 1'b0);
    chk("loop8_rx", rx, rx_exp8(8'hC3));

    // Random traffic with occasional resets.
    repeat (400) cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 60) == 0);
    repeat (FL + 2) cycle(1'b0, 8'h00, 1'b0);

    // Loopback WIDTH=2.
    w2 = 2'b10;
    chk("w2_ready_idle", {7'd0, load_ready2}, 8'd1);
    load_valid2 = 1'b1;
    p_in2       = w2;
    @(posedge clk);
    #1;
    load_valid2 = 1'b0;
    repeat (FL2 - 1) @(posedge clk);
    #1;
    chk("w2_s_last", {7'd0, s_last2}, 8'd1);
    @(posedge clk);
    #1;
    chk("loop2_rx", {6'd0, rx2}, {6'd0, (Par ? {w2[0], ^w2} : w2)});
    chk("w2_idle_valid", {7'd0, s_valid2}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
